muxn_rr_reg: RTL and testbench

Parametrised N-input, WIDTH-bit registered multiplexer. It is the sequential successor to the 2:1 datapath mux.
- Inputs are valid/ready channels.
- Channel selection is either by external select or by internal round-robin arbitration.
- The result is held in a one-entry output register with a valid/ready handshake.
- Used where several pipeline sources contend for one downstream path, e.g. writeback/LSU return merging.

---
 rtl/muxn_pkg.sv | 24 ++
 rtl/muxn_rr_reg_rr_arbiter.sv | 32 +++
 rtl/muxn_rr_reg.sv | 141 ++++++++++++++
 tb/tb_muxn_rr_reg.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared definitions for the registered N:1 mux: mode encoding and a one-hot to index helper.
package muxn_pkg;

    typedef logic [0:0] mux_mode_t;

    localparam mux_mode_t MUX_MODE_SEL = 1'b0;
    localparam mux_mode_t MUX_MODE_RR  = 1'b1;

    localparam int unsigned MAX_IN = 16;
    localparam int unsigned IDX_W  = 4;

    // OR-reduction encoder; result is only meaningful for one-hot (or zero) input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_IN-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_IN; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/muxn_rr_reg_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr+1 (with wrap) wins.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int unsigned  NUM_IN = 4,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic [SEL_W-1:0] k;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        k       = '0;
        for (int unsigned i = 1; i <= NUM_IN; i++) begin
            k = SEL_W'((32'(ptr_i) + i) % NUM_IN);
            if (!found && req_i[k]) begin
                grant_o[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign idx_o = SEL_W'(onehot_to_idx(MAX_IN'(grant_o)));

endmodule

// File: rtl/muxn_rr_reg.sv
// Registered N:1 valid/ready mux with external-select or round-robin channel choice.
// Optional stall counter output o_stall_cnt when MUXN_RR_PERF_EN is defined.
module muxn_rr_reg
    import muxn_pkg::*;
#(
    parameter int unsigned  WIDTH  = 32,
    parameter int unsigned  NUM_IN = 4,
    parameter mux_mode_t    MODE   = MUX_MODE_SEL,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_IN*WIDTH-1:0] i_data,
    input  logic [NUM_IN-1:0]       i_valid,
    output logic [NUM_IN-1:0]       o_ready,
    input  logic [SEL_W-1:0]        i_sel,
    output logic [WIDTH-1:0]        o_data,
    output logic [SEL_W-1:0]        o_src,
    output logic                    o_valid,
    input  logic                    i_ready
`ifdef MUXN_RR_PERF_EN
    ,
    output logic [15:0]             o_stall_cnt
`endif
);

    logic [WIDTH-1:0]  ch_data [NUM_IN];
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  idx;
    logic              load_en;
    logic              xfer;

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [SEL_W-1:0]  src_q,   src_d;

    always_comb begin
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            ch_data[k] = i_data[k*WIDTH +: WIDTH];
        end
    end

    assign load_en = !valid_q || i_ready;
    assign o_ready = grant & {NUM_IN{load_en && i_rst_n}};
    assign xfer    = |(i_valid & o_ready);

    generate
        if (MODE == MUX_MODE_RR) begin : gen_rr
            logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
            logic             unused_sel;

            assign unused_sel = ^i_sel;

            rr_arbiter #(
                .NUM_IN (NUM_IN)
            ) u_arb (
                .req_i   (i_valid),
                .ptr_i   (rr_ptr_q),
                .grant_o (grant),
                .idx_o   (idx)
            );

            // Pointer only moves on a real transfer so ungranted requesters keep their place.
            always_comb begin
                rr_ptr_d = rr_ptr_q;
                if (xfer) begin
                    rr_ptr_d = idx;
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rr_ptr_q <= SEL_W'(NUM_IN - 1);
                end else begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end
        end else begin : gen_sel
            // Out-of-range selects produce no grant.
            always_comb begin
                grant = '0;
                idx   = i_sel;
                if (32'(i_sel) < NUM_IN) begin
                    grant[i_sel] = i_valid[i_sel];
                end
            end
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = ch_data[idx];
            src_d   = idx;
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_src   = src_q;

`ifdef MUXN_RR_PERF_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles the held result is blocked downstream.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !i_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed bench for muxn_rr_reg: select and round-robin 4-input instances plus a 5-input select instance.
module tb_muxn_rr_reg;
    import muxn_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] data;
    logic [3:0]   valid;
    logic         rdy;
    logic [1:0]   sel0;
    logic [1:0]   sel1;

    logic [3:0]   o_ready0, o_ready1;
    logic [31:0]  o_data0,  o_data1;
    logic [1:0]   o_src0,   o_src1;
    logic         o_valid0, o_valid1;

    logic [159:0] data5;
    logic [4:0]   valid5;
    logic [2:0]   sel5;
    logic [4:0]   o_ready5;
    logic [31:0]  o_data5;
    logic [2:0]   o_src5;
    logic         o_valid5;

`ifdef MUXN_RR_PERF_EN
    logic [15:0]  stall0, stall1, stall5;
`endif

    exp_t q0[$];
    exp_t q1[$];
    int   mptr;
    int   n_chk;
    int   n_err;

    muxn_rr_reg #(.WIDTH(32), .NUM_IN(4), .MODE(MUX_MODE_SEL)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(o_ready0),
        .i_sel(sel0), .o_data(o_data0), .o_src(o_src0), .o_valid(o_valid0), .i_ready(rdy)
`ifdef MUXN_RR_PERF_EN
        , .o_stall_cnt(stall0)
`endif
    );

    muxn_rr_reg #(.WIDTH(32), .NUM_IN(4), .MODE(MUX_MODE_RR)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(o_ready1),
        .i_sel(sel1), .o_data(o_data1), .o_src(o_src1), .o_valid(o_valid1), .i_ready(rdy)
`ifdef MUXN_RR_PERF_EN
        , .o_stall_cnt(stall1)
`endif
    );

    muxn_rr_reg #(.WIDTH(32), .NUM_IN(5), .MODE(MUX_MODE_SEL)) u5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data5), .i_valid(valid5), .o_ready(o_ready5),
        .i_sel(sel5), .o_data(o_data5), .o_src(o_src5), .o_valid(o_valid5), .i_ready(1'b1)
`ifdef MUXN_RR_PERF_EN
        , .o_stall_cnt(stall5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int grant_sel(input logic [3:0] v, input logic [1:0] s);
        return v[s] ? int'(s) : -1;
    endfunction

    function automatic int grant_rr(input logic [3:0] v, input int p);
        for (int i = 1; i <= 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int g);
        logic [3:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic rand_data();
        for (int k = 0; k < 4; k++) data[k*32 +: 32] = $urandom;
    endtask

    // Check both 4-input instances against the queues, then advance one clock.
    task automatic cycle();
        int  g0, g1;
        bit  le0, le1;
        #1;
        chk("u0_valid", 64'(o_valid0), 64'(q0.size() != 0));
        if (q0.size() != 0) begin
            chk("u0_data", 64'(o_data0), 64'(q0[0].d));
            chk("u0_src",  64'(o_src0),  64'(q0[0].s));
        end
        chk("u1_valid", 64'(o_valid1), 64'(q1.size() != 0));
        if (q1.size() != 0) begin
            chk("u1_data", 64'(o_data1), 64'(q1[0].d));
            chk("u1_src",  64'(o_src1),  64'(q1[0].s));
        end
        g0  = grant_sel(valid, sel0);
        g1  = grant_rr(valid, mptr);
        le0 = (q0.size() == 0) || rdy;
        le1 = (q1.size() == 0) || rdy;
        chk("u0_ready", 64'(o_ready0), 64'(le0 ? oh(g0) : 4'b0000));
        chk("u1_ready", 64'(o_ready1), 64'(le1 ? oh(g1) : 4'b0000));
        if (q0.size() != 0 && rdy) void'(q0.pop_front());
        if (le0 && g0 >= 0) q0.push_back('{d: data[g0*32 +: 32], s: 2'(g0)});
        if (q1.size() != 0 && rdy) void'(q1.pop_front());
        if (le1 && g1 >= 0) begin
            q1.push_back('{d: data[g1*32 +: 32], s: 2'(g1)});
            mptr = g1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        mptr   = 3;
        rst_n  = 1'b0;
        data   = '0;
        valid  = '0;
        rdy    = 1'b0;
        sel0   = '0;
        sel1   = '0;
        data5  = '0;
        valid5 = '0;
        sel5   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid0", 64'(o_valid0), 64'(0));
        chk("rst_data1",  64'(o_data1),  64'(0));
        chk("rst_ready1", 64'(o_ready1), 64'(0));
        chk("rst_ready5", 64'(o_ready5), 64'(0));
        rst_n = 1'b1;

        // 5-input select: out-of-range selects are masked, sel=4 is a real channel
        for (int k = 0; k < 5; k++) data5[k*32 +: 32] = 32'h5500_0000 + 32'(k);
        valid5 = 5'b11111;
        sel5   = 3'd5;
        #1 chk("n5_sel5_ready", 64'(o_ready5), 64'(0));
        cycle();
        chk("n5_sel5_valid", 64'(o_valid5), 64'(0));
        sel5 = 3'd7;
        #1 chk("n5_sel7_ready", 64'(o_ready5), 64'(0));
        cycle();
        sel5 = 3'd4;
        #1 chk("n5_sel4_ready", 64'(o_ready5), 64'(5'b10000));
        cycle();
        chk("n5_sel4_valid", 64'(o_valid5), 64'(1));
        chk("n5_sel4_src",   64'(o_src5),   64'(4));
        chk("n5_sel4_data",  64'(o_data5),  64'(32'h5500_0004));
        valid5 = '0;

        // select DEADBEEF on ch2 while the arbiter starts its rotation at ch0
        rand_data();
        data[2*32 +: 32] = 32'hDEAD_BEEF;
        valid = 4'b1111;
        rdy   = 1'b1;
        sel0  = 2'd2;
        cycle();
        for (int i = 0; i < 6; i++) begin
            rand_data();
            sel0 = 2'(i);
            cycle();
        end

        // backpressure for 3 cycles, then drain and reload in the same cycle
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle();
        end
        rdy = 1'b1;
        rand_data();
        cycle();
        cycle();

        // dropped valids drain the output; a lone requester streams without bubbles
        valid = 4'b0000;
        cycle();
        valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle();
        end

        // reset while holding data: outputs clear asynchronously
        valid = 4'b1111;
        rdy   = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid0", 64'(o_valid0), 64'(0));
        chk("mid_rst_valid1", 64'(o_valid1), 64'(0));
        chk("mid_rst_data1",  64'(o_data1),  64'(0));
        chk("mid_rst_src1",   64'(o_src1),   64'(0));
        chk("mid_rst_ready1", 64'(o_ready1), 64'(0));
        q0.delete();
        q1.delete();
        mptr = 3;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // sparse requesters ch1/ch3 from reset pointer
        valid = 4'b1010;
        rdy   = 1'b1;
        sel0  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            cycle();
        end
        chk("sparse_last_src", 64'(o_src1), 64'(3));

`ifdef MUXN_RR_PERF_EN
        valid = 4'b0001;
        rdy   = 1'b0;
        cycle();
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("stall_sat", 64'(stall0), 64'(16'hFFFF));
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_hold", 64'(stall0), 64'(16'hFFFF));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
